// File: rtl/sdram_arbiter_n.sv
// sdram_arbiter_n: shares one single-transfer SDRAM bridge among N_CLIENTS requesters.
// One transfer is in flight at a time; clients are chosen round-robin or by fixed priority.
module sdram_arbiter_n #(
    parameter int N_CLIENTS = 4,
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 128,
    parameter int RR_MODE   = 1,
    parameter int TIMEOUT   = 1023
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [N_CLIENTS-1:0]            cl_rd,
    input  logic [N_CLIENTS-1:0]            cl_wr,
    input  logic [N_CLIENTS*ADDR_W-1:0]     cl_addr,
    input  logic [N_CLIENTS*DATA_W-1:0]     cl_wrdata,
    input  logic [N_CLIENTS*DATA_W/8-1:0]   cl_be,
    output logic [N_CLIENTS-1:0]            cl_ac,
    output logic [N_CLIENTS-1:0]            cl_wait,
    output logic [DATA_W-1:0]               cl_rddata,
    output logic [ADDR_W+3:0]               br_address,
    output logic [DATA_W/8-1:0]             br_byte_enable,
    output logic                            br_read,
    output logic                            br_write,
    output logic [DATA_W-1:0]               br_write_data,
    input  logic                            br_acknowledge,
    input  logic [DATA_W-1:0]               br_read_data,
    output logic [$clog2(N_CLIENTS)-1:0]    grant_id,
    output logic                            busy,
    output logic                            timeout_err
);
    localparam int GW = $clog2(N_CLIENTS);
    localparam int BW = DATA_W / 8;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d, last_q, last_d, sel;
    logic [ADDR_W-1:0]    addr_q, addr_d, sel_addr;
    logic [DATA_W-1:0]    wdata_q, wdata_d, sel_wdata;
    logic [BW-1:0]        be_q, be_d, sel_be;
    logic [DATA_W-1:0]    rddata_q, rddata_d;
    logic                 rd_q, rd_d, wr_q, wr_d;
    logic                 terr_q, terr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [N_CLIENTS-1:0] req, ac_q, ac_d;
    logic                 found, sel_wr;

    // Arbitration: RR walks last_q+1, last_q+2, ... with wrap; the nearest hit is written last.
    always_comb begin
        req   = cl_rd | cl_wr;
        found = 1'b0;
        sel   = '0;
        if (RR_MODE != 0) begin
            for (int k = N_CLIENTS; k >= 1; k--) begin
                for (int i = 0; i < N_CLIENTS; i++) begin
                    if (req[i] && (i == (int'(last_q) + k) % N_CLIENTS)) begin
                        found = 1'b1;
                        sel   = GW'(i);
                    end
                end
            end
        end else begin
            for (int i = N_CLIENTS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    found = 1'b1;
                    sel   = GW'(i);
                end
            end
        end
    end

    // A client raising both rd and wr gets its write first; the read stays pending.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (i == int'(sel)) begin
                sel_addr  = cl_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = cl_wrdata[i*DATA_W +: DATA_W];
                sel_be    = cl_be[i*BW +: BW];
                sel_wr    = cl_wr[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rddata_d = rddata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        terr_d   = terr_q;
        cnt_d    = cnt_q;
        ac_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ISSUE;
                    grant_d = sel;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    be_d    = sel_be;
                    wr_d    = sel_wr;
                    rd_d    = ~sel_wr;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                if (br_acknowledge) begin
                    rddata_d      = br_read_data;
                    rd_d          = 1'b0;
                    wr_d          = 1'b0;
                    last_d        = grant_q;
                    ac_d[grant_q] = 1'b1;
                    state_d       = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rddata_d      = '0;
                    rd_d          = 1'b0;
                    wr_d          = 1'b0;
                    terr_d        = 1'b1;
                    last_d        = grant_q;
                    ac_d[grant_q] = 1'b1;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= GW'(N_CLIENTS - 1);
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rddata_q <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            terr_q   <= 1'b0;
            cnt_q    <= '0;
            ac_q     <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rddata_q <= rddata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            terr_q   <= terr_d;
            cnt_q    <= cnt_d;
            ac_q     <= ac_d;
        end
    end

    assign cl_ac          = ac_q;
    assign cl_wait        = req & ~ac_q;
    assign cl_rddata      = rddata_q;
    assign br_address     = {addr_q, 4'b0000};
    assign br_byte_enable = be_q;
    assign br_read        = rd_q;
    assign br_write       = wr_q;
    assign br_write_data  = wdata_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q != IDLE);
    assign timeout_err    = terr_q;

endmodule
